muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the architectural HI/LO registers in the 5-stage MIPS pipeline.
- Sits in EX, driven by the 8-bit alucontrol code from the ALU decoder.
- Holds the pipeline via `stall` while an iterative divide or multi-cycle multiply runs, then commits the 64-bit result to HI/LO.
- Also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

Parameters:
- MUL_CYCLES, 2, number of MUL_WAIT cycles before the multiply result is valid (1..8).
- DIV_BITS, 32, divider iterations; fixed at 32 for this ISA, exposed for bench speed-up only.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- alucontrol  in  8  EX op code (EXE_*_OP values)
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- flush  in  1  cancel EX instruction (exception/redirect)
- pipe_hold  in  1  downstream stall from another source; result may not commit
- stall  out  1  hold IF/ID/EX
- busy  out  1  FSM not in IDLE
- hi_o  out  32  current HI
- lo_o  out  32  current LO

Behaviour:
- Clock and reset: single clock `clk`; reset `resetn` is synchronous, active-low.
- Reset values: state=IDLE, hi_o=0, lo_o=0, busy=0, stall=0, counter=0.
  - Reset mid-operation aborts the op with no HI/LO write.
- Start: in IDLE, `start = ex_valid & !flush & op∈{MULT,MULTU,DIV,DIVU}`.
  - In the start cycle T, latch src_a/src_b and the op; stall=1 combinationally.
- FSM states and transitions:
  - IDLE: start(mul) -> MUL_WAIT; start(div) -> DIV_RUN.
  - MUL_WAIT: counter counts MUL_CYCLES cycles -> DONE. Signed or unsigned 64-bit product per op.
  - DIV_RUN: restoring divide of operand magnitudes, one quotient bit per cycle, DIV_BITS cycles -> DIV_FIX.
  - DIV_FIX: one cycle. Quotient negated if sign(a)^sign(b); remainder takes sign(a); signed ops only -> DONE.
  - DONE: stall=0. If !pipe_hold, write HI=high/remainder and LO=low/quotient at the clock edge -> IDLE. Else remain in DONE, no write.
- Stall rule: stall = start | (state∈{MUL_WAIT, DIV_RUN, DIV_FIX}).
  - DIV: stall is high T..T+33 (34 cycles); commit at T+34.
  - MUL: stall is high for MUL_CYCLES+1 cycles.
- Edge-case results:
  - Divide by zero (signed or unsigned): full latency, HI=src_a, LO=0xFFFFFFFF, no trap.
  - 0x80000000 DIV 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: in IDLE with ex_valid & !flush & !pipe_hold, write src_a to HI or LO at the clock edge. No stall.
  - Visible on hi_o/lo_o the next cycle.
  - MTHI/MTLO while not IDLE cannot occur because the pipeline is stalled; if it does, it is ignored.
- Flush:
  - In any non-IDLE state, flush forces IDLE next cycle, with no HI/LO write and stall=0 in the flush cycle.
  - Flush with start in the same cycle: no start.
- hi_o/lo_o are register outputs. MFHI/MFLO read them directly; this block provides no write forwarding.
- Unknown alucontrol (including 8'hff) is ignored.

Decomposition:
- Shared package/defines, reused from the existing defines headers:
  - op codes EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP;
  - FSM state encoding constants (IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE).
- One natural sub-module: `div_iter`, the 32-bit restoring divider core.
  - Interface: load, step, unsigned dividend/divisor in; quotient/remainder out.
  - The sequencer owns counting, sign handling and HI/LO.

Test Plan:
- MULT src_a=0xFFFFFFFF, src_b=2 -> stall for 3 cycles (MUL_CYCLES=2), then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> stall high exactly 34 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU src_a=7, src_b=0 -> 34-cycle stall, then HI=0x00000007, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV started with HI=LO=0x11111111; flush asserted in cycle T+10 -> stall=0 that cycle, IDLE next cycle, HI/LO still 0x11111111.
- MTHI src_a=0x12345678 -> hi_o=0x12345678 next cycle, stall never asserted. Repeat with pipe_hold=1 -> no write.
- MULT completes with pipe_hold=1 for 3 cycles in DONE -> no write, stall=0 throughout, write on the first cycle pipe_hold=0. resetn=0 mid-DIV -> hi_o=lo_o=0, busy=0 next cycle.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared op codes, sequencer state encoding and sign helper for the HI/LO
// multiply/divide unit.
package muldiv_hilo_ctrl_pkg;

    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Wide enough for DIV_BITS-1 = 31 as the down-counter preload.
    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_WAIT = 3'd1,
        DIV_RUN  = 3'd2,
        DIV_FIX  = 3'd3,
        DONE     = 3'd4
    } state_e;

    // Two's-complement negate when neg is set; used both to take operand
    // magnitudes and to restore result signs.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_div_iter.sv
// Restoring unsigned divider core: one quotient bit per step, MSB first.
module muldiv_hilo_ctrl_div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [32:0] trial;

    // The partial remainder stays below the divisor, so shifted < 2*divisor and a
    // non-negative trial always fits back into 32 bits.
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer and owner of the architectural HI/LO
// registers; stalls the front of the pipe while an operation is in flight.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no op in flight; accepts start and MTHI/MTLO
//   MUL_WAIT | product settling, MUL_CYCLES cycles
//   DIV_RUN  | restoring divide, one quotient bit per cycle
//   DIV_FIX  | apply result signs and divide-by-zero values
//   DONE     | result ready; commits to HI/LO once pipe_hold drops
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_BITS   = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [7:0]  alucontrol,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        pipe_hold,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;

    logic             is_mul_op;
    logic             is_div_op;
    logic             is_signed_op;
    logic             start;

    logic             div_load;
    logic             div_step;
    logic             commit;
    logic             mthi_we;
    logic             mtlo_we;

    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             op_signed;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic [31:0]      div_quo;
    logic [31:0]      div_rem;
    logic [31:0]      fix_quo;
    logic [31:0]      fix_rem;
    logic [63:0]      ext_a;
    logic [63:0]      ext_b;
    logic [63:0]      product;

    assign is_mul_op    = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_MULTU_OP);
    assign is_div_op    = (alucontrol == EXE_DIV_OP)  || (alucontrol == EXE_DIVU_OP);
    assign is_signed_op = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_DIV_OP);
    assign start        = (state == IDLE) && ex_valid && !flush && (is_mul_op || is_div_op);
    assign cnt_tc       = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = is_mul_op ? MUL_WAIT : DIV_RUN;
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt_tc) begin
                    state_nxt = DONE;
                end
            end
            DIV_RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt_tc) begin
                    state_nxt = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_nxt = flush ? IDLE : DONE;
            end
            DONE: begin
                if (flush || !pipe_hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        commit   = 1'b0;
        mthi_we  = 1'b0;
        mtlo_we  = 1'b0;
        case (state)
            IDLE: begin
                stall    = start;
                div_load = start && is_div_op;
                mthi_we  = ex_valid && !flush && !pipe_hold && (alucontrol == EXE_MTHI_OP);
                mtlo_we  = ex_valid && !flush && !pipe_hold && (alucontrol == EXE_MTLO_OP);
            end
            MUL_WAIT, DIV_FIX: begin
                stall = !flush;
            end
            DIV_RUN: begin
                stall    = !flush;
                div_step = !flush;
            end
            DONE: begin
                commit = !flush && !pipe_hold;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    muldiv_hilo_ctrl_div_iter u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .load      (div_load),
        .step      (div_step),
        .dividend  (neg_if(src_a, is_signed_op && src_a[31])),
        .divisor   (neg_if(src_b, is_signed_op && src_b[31])),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign-extending to 64 bits lets one unsigned multiply serve both MULT and MULTU.
    assign ext_a   = {{32{op_signed & op_a[31]}}, op_a};
    assign ext_b   = {{32{op_signed & op_b[31]}}, op_b};
    assign product = ext_a * ext_b;

    // Divide by zero returns the dividend in HI and all-ones in LO regardless of signedness.
    always_comb begin
        if (op_b == '0) begin
            fix_quo = '1;
            fix_rem = op_a;
        end else begin
            fix_quo = neg_if(div_quo, op_signed && (op_a[31] ^ op_b[31]));
            fix_rem = neg_if(div_rem, op_signed && op_a[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            res_hi    <= '0;
            res_lo    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (start) begin
                op_a      <= src_a;
                op_b      <= src_b;
                op_signed <= is_signed_op;
                cnt       <= is_mul_op ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_BITS - 1);
            end else if ((state == MUL_WAIT || state == DIV_RUN) && !cnt_tc) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (state == MUL_WAIT && cnt_tc) begin
                res_hi <= product[63:32];
                res_lo <= product[31:0];
            end else if (state == DIV_FIX) begin
                res_hi <= fix_rem;
                res_lo <= fix_quo;
            end

            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                if (mthi_we) begin
                    hi_q <= src_a;
                end
                if (mtlo_we) begin
                    lo_q <= src_a;
                end
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: an arithmetic HI/LO model plus an expected
// stall/busy timeline, compared every cycle, with literal spot checks.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    localparam int MUL_CYCLES = 2;
    localparam int DIV_BITS   = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid;
    logic [7:0]  alucontrol;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        pipe_hold;
    logic        stall;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          checks     = 0;
    int          errors     = 0;
    int          stall_seen = 0;
    logic        chk_en     = 1'b0;
    logic        exp_stall  = 1'b0;
    logic        exp_busy   = 1'b0;
    logic [31:0] mdl_hi     = '0;
    logic [31:0] mdl_lo     = '0;

    always #5 clk = ~clk;

    muldiv_hilo_ctrl #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_BITS   (DIV_BITS)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ex_valid   (ex_valid),
        .alucontrol (alucontrol),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .pipe_hold  (pipe_hold),
        .stall      (stall),
        .busy       (busy),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // {HI, LO} as the ISA defines them, from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            EXE_MULT_OP:  return sa * sb;
            EXE_MULTU_OP: return ua * ub;
            EXE_DIVU_OP:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            EXE_DIV_OP:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default:      return 64'd0;
        endcase
    endfunction

    // One clock: compare mid-cycle, then move to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("busy",  32'(busy),  32'(exp_busy));
            check("hi_o",  hi_o, mdl_hi);
            check("lo_o",  lo_o, mdl_lo);
            if (stall === 1'b1) stall_seen++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int hold);
        logic [63:0] r;
        int          lat;
        r          = model(op, a, b);
        lat        = (op == EXE_MULT_OP || op == EXE_MULTU_OP) ? MUL_CYCLES : DIV_BITS + 1;
        stall_seen = 0;
        ex_valid   = 1'b1;
        alucontrol = op;
        src_a      = a;
        src_b      = b;
        exp_stall  = 1'b1;
        exp_busy   = 1'b0;
        tick();
        ex_valid   = 1'b0;
        alucontrol = 8'h00;
        src_a      = 32'hDEAD_BEEF;
        src_b      = 32'h0BAD_F00D;
        for (int k = 1; k <= lat; k++) begin
            exp_busy = 1'b1;
            if (k == flush_at) begin
                flush     = 1'b1;
                exp_stall = 1'b0;
                tick();
                flush    = 1'b0;
                exp_busy = 1'b0;
                return;
            end
            exp_stall = 1'b1;
            tick();
        end
        exp_stall = 1'b0;
        exp_busy  = 1'b1;
        for (int h = 0; h < hold; h++) begin
            pipe_hold = 1'b1;
            tick();
        end
        pipe_hold = 1'b0;
        tick();
        mdl_hi   = r[63:32];
        mdl_lo   = r[31:0];
        exp_busy = 1'b0;
    endtask

    task automatic mt(input logic [7:0] op, input logic [31:0] a, input logic hold);
        stall_seen = 0;
        ex_valid   = 1'b1;
        alucontrol = op;
        src_a      = a;
        pipe_hold  = hold;
        exp_stall  = 1'b0;
        exp_busy   = 1'b0;
        tick();
        ex_valid   = 1'b0;
        alucontrol = 8'h00;
        pipe_hold  = 1'b0;
        if (!hold) begin
            if (op == EXE_MTHI_OP) mdl_hi = a;
            if (op == EXE_MTLO_OP) mdl_lo = a;
        end
    endtask

    initial begin
        resetn     = 1'b0;
        ex_valid   = 1'b0;
        flush      = 1'b0;
        pipe_hold  = 1'b0;
        alucontrol = 8'h00;
        src_a      = '0;
        src_b      = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        resetn = 1'b1;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        tick();

        run_op(EXE_MULT_OP, 32'hFFFF_FFFF, 32'd2, 0, 0);
        check("mult_stall_cycles", 32'(stall_seen), 32'd3);
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFFE);

        run_op(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, 0, 0);
        check("multu_hi", hi_o, 32'h0000_0001);
        check("multu_lo", lo_o, 32'hFFFF_FFFE);

        run_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_stall_cycles", 32'(stall_seen), 32'd34);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);

        run_op(EXE_DIVU_OP, 32'd100, 32'd7, 0, 0);
        check("divu_lo", lo_o, 32'd14);
        check("divu_hi", hi_o, 32'd2);

        run_op(EXE_DIVU_OP, 32'd7, 32'd0, 0, 0);
        check("divu0_stall_cycles", 32'(stall_seen), 32'd34);
        check("divu0_hi", hi_o, 32'h0000_0007);
        check("divu0_lo", lo_o, 32'hFFFF_FFFF);

        run_op(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("divovf_lo", lo_o, 32'h8000_0000);
        check("divovf_hi", hi_o, 32'h0);

        run_op(EXE_DIV_OP, 32'd100, 32'hFFFF_FFF9, 0, 0);
        run_op(EXE_DIV_OP, 32'hFFFF_FFFB, 32'd0, 0, 0);
        check("div0_signed_hi", hi_o, 32'hFFFF_FFFB);
        check("div0_signed_lo", lo_o, 32'hFFFF_FFFF);

        mt(EXE_MTHI_OP, 32'h1111_1111, 1'b0);
        mt(EXE_MTLO_OP, 32'h1111_1111, 1'b0);
        run_op(EXE_DIV_OP, 32'd1000, 32'd3, 10, 0);
        tick();
        check("flush_hi", hi_o, 32'h1111_1111);
        check("flush_lo", lo_o, 32'h1111_1111);
        check("flush_busy", 32'(busy), 32'h0);

        mt(EXE_MTHI_OP, 32'h1234_5678, 1'b0);
        check("mthi_hi", hi_o, 32'h1234_5678);
        check("mthi_no_stall", 32'(stall_seen), 32'd0);
        mt(EXE_MTHI_OP, 32'hCAFE_F00D, 1'b1);
        check("mthi_hold_hi", hi_o, 32'h1234_5678);
        mt(EXE_MTLO_OP, 32'h0000_ABCD, 1'b0);
        mt(8'hFF, 32'h5555_5555, 1'b0);
        tick();

        ex_valid   = 1'b1;
        alucontrol = EXE_DIV_OP;
        src_a      = 32'd50;
        src_b      = 32'd5;
        flush      = 1'b1;
        exp_stall  = 1'b0;
        exp_busy   = 1'b0;
        tick();
        ex_valid   = 1'b0;
        flush      = 1'b0;
        alucontrol = 8'h00;
        tick();

        run_op(EXE_MULT_OP, 32'd3, 32'hFFFF_FFFB, 0, 3);
        check("mult_hold_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_hold_lo", lo_o, 32'hFFFF_FFF1);

        ex_valid   = 1'b1;
        alucontrol = EXE_DIV_OP;
        src_a      = 32'd1000;
        src_b      = 32'd3;
        exp_stall  = 1'b1;
        exp_busy   = 1'b0;
        tick();
        ex_valid   = 1'b0;
        alucontrol = 8'h00;
        exp_busy   = 1'b1;
        repeat (5) tick();
        resetn = 1'b0;
        chk_en = 1'b0;
        tick();
        resetn    = 1'b1;
        chk_en    = 1'b1;
        exp_stall = 1'b0;
        exp_busy  = 1'b0;
        mdl_hi    = '0;
        mdl_lo    = '0;
        check("rstmid_hi", hi_o, 32'h0);
        check("rstmid_lo", lo_o, 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
